planificador_ascensor: RTL and testbench
========================================

# planificador_ascensor

Trip scheduler for the 4-floor elevator. It latches hall and cabin button presses into a pending-request register and owns the car state word (floor, direction, moving). It sequences floor-to-floor travel with a per-floor travel counter and hands each stop to the door controller, holding the car until the doors have cycled and closed. Its `solicitudes` and `estado` outputs are the request and state inputs of the door controller.

## Interface
Parameters:
- `T_PISO`, default 16: clock cycles to travel one floor; legal range 1..255.

Ports:
- `clk` input 1: clock. One clock domain; all state changes on the rising edge.
- `reset_n` input 1: reset. Synchronous, active-low.
- `botones` input 10: button pulses, one cycle each.
  - [0] floor 0 up; [1] floor 1 up; [2] floor 1 down; [3] floor 2 up; [4] floor 2 down; [5] floor 3 down.
  - [6+f] cabin button for floor f.
- `puertas` input 2: door state. 00 closed, 01 open, 10 opening, 11 closing.
- `trabajando` input 1: door controller busy.
- `solicitudes` output 10: pending-request register, same bit map as `botones`.
- `estado` output 4: car state.
  - [1:0] floor 0..3.
  - [2] direction: 0 up, 1 down.
  - [3] moving.
- `motor` output 2: 00 stop, 01 up, 10 down. 11 is never driven.

## Operation
- Pending register.
  - Each cycle: `solicitudes <= (solicitudes | botones) & ~clear`.
  - A clear wins over a same-cycle press of the same bit.
- Demand definitions, relative to floor f:
  - `arriba`: any pending bit for a floor above f.
  - `abajo`: any pending bit for a floor below f.
  - `aqui(d)`: cabin[f], or the hall bit at f for direction d. At floor 0, hall bit [0] counts for either direction; at floor 3, hall bit [5] counts for either direction.
- FSM states: REPOSO, MOVIENDO, PUERTAS. Reset state is REPOSO.
- REPOSO. Evaluated only when `puertas==00` and `trabajando==0`:
  - If `aqui(dir)` or `aqui(!dir)`: go to PUERTAS. Set dir to the direction of the matching hall bit; if only cabin[f] matches, keep dir.
  - Else if `arriba` and not (`abajo` and dir==1): set dir=0, `motor=01`, go to MOVIENDO.
  - Else if `abajo`: set dir=1, `motor=10`, go to MOVIENDO.
  - Else: stay in REPOSO.
- MOVIENDO:
  - `estado[3]=1`. The travel counter loads 0 on entry and increments each cycle.
  - At count T_PISO-1: floor ±1 according to dir, counter reloads, and the stop test runs on the new floor.
  - Stop test:
    - Stop if `aqui(dir)`.
    - Stop if the new floor is the end of travel in dir.
    - Stop if there is no demand beyond the new floor in dir and `aqui(!dir)`. In that case dir flips before PUERTAS.
  - On stop: `motor=00`, `estado[3]=0`, go to PUERTAS.
  - If there is no demand at all: stop too (this cannot occur without a reset).
- PUERTAS:
  - `estado[3]=0`, `motor=00`.
  - On the first cycle with `puertas==01`, assert clear for cabin[f] and the hall bit `aqui(dir)` at f (one pulse), and set the `abierto` flag.
  - Once `abierto`, `puertas==00` and `trabajando==0`: clear `abierto`, go to REPOSO.
  - While in PUERTAS, presses at the current floor re-latch normally. The door controller reopens on them, and a second `puertas==01` event clears again.
- Invariants:
  - `motor!=00` only in MOVIENDO.
  - MOVIENDO is never entered unless `puertas==00`.
  - Floor never leaves 0..3.

## Timing
- Reset values: `solicitudes=0`, `estado=4'b0000` (floor 0, up, stopped), `motor=00`, counter=0, `abierto=0`, state REPOSO.
- Reset is honored in any state, including mid-travel. The car position reinitialises to floor 0.
- A press in cycle n is visible on `solicitudes` at n+1.
- REPOSO to MOVIENDO: `motor` and `estado[3]` change one cycle after the decision inputs are sampled.
- One floor takes exactly T_PISO cycles in MOVIENDO. The floor field updates at the same edge as the stop decision.
- The clear of served bits lands on the edge after the first `puertas==01` sample.
- PUERTAS to REPOSO: 1 cycle after closed-and-idle is sampled. A new trip can start no earlier than the following cycle.

## Test plan
- Reset behaviour: hold `reset_n=0` 3 cycles with random `botones` -> `solicitudes=0`, `estado=0000`, `motor=00`.
- Cabin call up: press `botones[8]` (floor 2) at floor 0, T_PISO=4, doors modelled -> `motor=01` for 8 cycles, `estado=4'b0010` stopped. After `puertas=01`, `solicitudes[8]=0`, then REPOSO.
- Hall pass-by: car moving up from 0 with `solicitudes[9]` set and floor-1 down (bit [2]) pending -> no stop at floor 1. Stop at 3, dir flips to down, then the car serves floor 1 and clears bit 2.
- Same-floor call: idle at floor 1, press bit [1] -> PUERTAS with no motion. Bit [1] clears on `puertas==01`. Also pulse bit [1] in the clear cycle -> the bit stays 0.
- Door interlock: pending call above with `puertas=01` held -> `motor` stays 00 until `puertas==00` and `trabajando==0`.
- Reset mid-travel: `reset_n=0` while `motor=10` between floors -> next cycle `motor=00`, `estado=0000`, pending cleared.

Source files
------------

// File: rtl/planificador_ascensor.sv
// planificador_ascensor: pending-call register and travel/door sequencing for a 4-floor car
module planificador_ascensor #(
   parameter int T_PISO = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] botones,
   input  logic [1:0] puertas,
   input  logic       trabajando,
   output logic [9:0] solicitudes,
   output logic [3:0] estado,
   output logic [1:0] motor
);
   typedef enum logic [1:0] {REPOSO, MOVIENDO, PUERTAS} estado_t;
   localparam logic [7:0] FIN = 8'(T_PISO - 1);
   estado_t st, st_n;
   logic [9:0] sol, clr;
   logic [7:0] cnt, cnt_n;
   logic [1:0] piso, piso_n, nf;
   logic dir, dir_n, abierto, abierto_n, prev_ab;
   function automatic logic [9:0] mp(input logic [1:0] f);
      return f == 2'd0 ? 10'h041 : f == 2'd1 ? 10'h086 : f == 2'd2 ? 10'h118 : 10'h220;
   endfunction
   function automatic logic [9:0] ma(input logic [1:0] f, input logic d);
      return (10'h040 << f) | (f == 2'd0 ? 10'h001 : f == 2'd3 ? 10'h020 :
             f == 2'd1 ? (d ? 10'h004 : 10'h002) : (d ? 10'h010 : 10'h008));
   endfunction
   // all request bits strictly beyond floor f in direction d
   function automatic logic [9:0] me(input logic [1:0] f, input logic d);
      logic [9:0] m;
      m = '0;
      for (int g = 0; g < 4; g++)
         if (d ? g < int'(f) : g > int'(f)) m |= mp(2'(g));
      return m;
   endfunction
   always_comb begin
      st_n = st;
      piso_n = piso;
      dir_n = dir;
      cnt_n = cnt;
      abierto_n = abierto;
      clr = '0;
      nf = dir ? piso - 2'd1 : piso + 2'd1;
      case (st)
         REPOSO: begin
            cnt_n = '0;
            if (puertas == 2'b00 && !trabajando) begin
               if (|(sol & (ma(piso, dir) | ma(piso, !dir)))) begin
                  st_n = PUERTAS;
                  dir_n = (!(|(sol & ma(piso, dir) & 10'h03f)) && |(sol & ma(piso, !dir) & 10'h03f)) ? !dir : dir;
               end else if (|(sol & me(piso, 1'b0)) && !(|(sol & me(piso, 1'b1)) && dir)) begin
                  st_n = MOVIENDO;
                  dir_n = 1'b0;
               end else if (|(sol & me(piso, 1'b1))) begin
                  st_n = MOVIENDO;
                  dir_n = 1'b1;
               end
            end
         end
         MOVIENDO: begin
            cnt_n = cnt + 8'd1;
            if (cnt == FIN) begin
               cnt_n = '0;
               piso_n = nf;
               if (|(sol & ma(nf, dir)) || (dir ? nf == 2'd0 : nf == 2'd3) || sol == '0)
                  st_n = PUERTAS;
               else if (!(|(sol & me(nf, dir))) && |(sol & ma(nf, !dir))) begin
                  st_n = PUERTAS;
                  dir_n = !dir;
               end
            end
         end
         PUERTAS: begin
            if (puertas == 2'b01 && !prev_ab) begin
               clr = ma(piso, dir);
               abierto_n = 1'b1;
            end else if (abierto && puertas == 2'b00 && !trabajando) begin
               abierto_n = 1'b0;
               st_n = REPOSO;
            end
         end
         default: st_n = REPOSO;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st <= REPOSO;
         sol <= '0;
         piso <= '0;
         dir <= 1'b0;
         cnt <= '0;
         abierto <= 1'b0;
         prev_ab <= 1'b0;
      end else begin
         st <= st_n;
         sol <= (sol | botones) & ~clr;
         piso <= piso_n;
         dir <= dir_n;
         cnt <= cnt_n;
         abierto <= abierto_n;
         prev_ab <= puertas == 2'b01;
      end
   end
   assign solicitudes = sol;
   assign estado = {st == MOVIENDO, dir, piso};
   assign motor = st != MOVIENDO ? 2'b00 : dir ? 2'b10 : 2'b01;
endmodule

// File: tb/tb_planificador_ascensor.sv
// tb_planificador_ascensor: scoreboard bench for the elevator trip scheduler
module tb_planificador_ascensor;
   logic clk, reset_n, trabajando;
   logic [9:0] botones, solicitudes;
   logic [1:0] puertas, motor;
   logic [3:0] estado;
   int n_cmp = 0, n_err = 0;
   int q[$];
   planificador_ascensor #(.T_PISO(4)) dut (
      .clk(clk), .reset_n(reset_n), .botones(botones), .puertas(puertas),
      .trabajando(trabajando), .solicitudes(solicitudes), .estado(estado), .motor(motor)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic esperar(input int e);
      q.push_back(e);
   endtask
   task automatic comparar(input string tag, input int obs);
      if (q.size() == 0) check({tag, "_vacio"}, obs, -1);
      else check(tag, obs, q.pop_front());
   endtask
   task automatic viaje(input string tag, input logic [1:0] m, input int n_exp, input logic [3:0] e_exp);
      int n = 0, w = 0;
      esperar(n_exp);
      esperar(int'(e_exp));
      esperar(0);
      while (motor != m && w < 20) begin tick; w++; end
      while (motor == m && n < 100) begin tick; n++; end
      comparar({tag, "_ciclos"}, n);
      comparar({tag, "_estado"}, int'(estado));
      comparar({tag, "_motor"}, int'(motor));
   endtask
   task automatic puertas_ciclo(input string tag, input int exp_sol, input logic [9:0] b_clr);
      esperar(exp_sol);
      esperar(exp_sol);
      puertas = 2'b10; trabajando = 1'b1; tick;
      puertas = 2'b01; botones = b_clr; tick;
      botones = '0;
      comparar({tag, "_sol"}, int'(solicitudes));
      tick;
      comparar({tag, "_sol_mantiene"}, int'(solicitudes));
      puertas = 2'b11; tick;
      puertas = 2'b00; trabajando = 1'b0; tick;
   endtask
   initial begin
      int n;
      clk = 0; reset_n = 0; botones = '0; puertas = 2'b00; trabajando = 1'b0;
      esperar(0); esperar(0); esperar(0);
      for (int i = 0; i < 3; i++) begin botones = 10'($urandom); tick; end
      botones = '0;
      comparar("rst_sol", int'(solicitudes));
      comparar("rst_estado", int'(estado));
      comparar("rst_motor", int'(motor));
      reset_n = 1;
      tick;
      // cabin call to floor 2 from floor 0
      esperar(10'h100);
      botones = 10'h100; tick; botones = '0;
      comparar("cab_sol", int'(solicitudes));
      viaje("cab", 2'b01, 8, 4'b0010);
      puertas_ciclo("cab", 0, '0);
      // restart from floor 0, pass by floor 1 going up
      reset_n = 0; tick; reset_n = 1; tick;
      botones = 10'h204; tick; botones = '0;
      viaje("paso_sube", 2'b01, 12, 4'b0011);
      puertas_ciclo("paso3", 10'h004, '0);
      viaje("paso_baja", 2'b10, 8, 4'b0101);
      puertas_ciclo("paso1", 0, '0);
      // same-floor hall call with a re-press during the clear cycle
      esperar(10'h002); esperar(4'b0001); esperar(0);
      botones = 10'h002; tick; botones = '0;
      comparar("mismo_sol", int'(solicitudes));
      tick;
      comparar("mismo_estado", int'(estado));
      comparar("mismo_motor", int'(motor));
      puertas_ciclo("mismo", 0, 10'h002);
      // door interlock
      esperar(0); esperar(0); esperar(2'b01);
      puertas = 2'b01;
      botones = 10'h200; tick; botones = '0;
      n = 0;
      for (int i = 0; i < 10; i++) begin tick; if (motor != 2'b00) n++; end
      comparar("bloq_abierta", n);
      puertas = 2'b00; trabajando = 1'b1;
      n = 0;
      for (int i = 0; i < 3; i++) begin tick; if (motor != 2'b00) n++; end
      comparar("bloq_trabajando", n);
      trabajando = 1'b0; tick;
      comparar("bloq_arranque", int'(motor));
      viaje("bloq", 2'b01, 8, 4'b0011);
      puertas_ciclo("bloq", 0, '0);
      // reset while travelling down between floors
      esperar(2'b10); esperar(0); esperar(0); esperar(0);
      botones = 10'h0c0; tick; botones = '0;
      n = 0;
      while (motor != 2'b10 && n < 20) begin tick; n++; end
      tick; tick;
      comparar("rmov_motor_antes", int'(motor));
      reset_n = 0; tick;
      comparar("rmov_motor", int'(motor));
      comparar("rmov_estado", int'(estado));
      comparar("rmov_sol", int'(solicitudes));
      reset_n = 1; tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
